// File: rtl/psram_xfer_arb_pkg.sv
// psram_xfer_arb_pkg
//   Shared definitions for the PSRAM transaction arbiter: FSM state
//   encodings and the width of the owner field (master index, or NUM_MST
//   for the config port).
package psram_xfer_arb_pkg;

  typedef enum logic [1:0] {
    PSRAM_ARB_IDLE  = 2'd0,
    PSRAM_ARB_ISSUE = 2'd1,
    PSRAM_ARB_BUSY  = 2'd2,
    PSRAM_ARB_RESP  = 2'd3
  } psram_arb_state_e;

  // Wide enough for up to 8 masters plus the config-port code.
  localparam int PSRAM_OWNER_W = 4;

endpackage

// File: rtl/psram_xfer_arb_rr.sv
// psram_xfer_arb_rr
//   Combinational round-robin pick. Scans requests starting at i_ptr and
//   wrapping, returning the first requester found.
// Ports:
//   i_req   [N-1:0]         request vector
//   i_ptr   [OWNER_W-1:0]   index with highest priority this cycle (< N)
//   o_gnt   [N-1:0]         one-hot winner (all zero if no request)
//   o_idx   [OWNER_W-1:0]   winner index
//   o_valid                 any request present
module psram_xfer_arb_rr
  import psram_xfer_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]             i_req,
  input  logic [PSRAM_OWNER_W-1:0] i_ptr,
  output logic [N-1:0]             o_gnt,
  output logic [PSRAM_OWNER_W-1:0] o_idx,
  output logic                     o_valid
);

  always_comb begin
    int   j;
    logic found;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!found && i_req[j]) begin
        found    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = PSRAM_OWNER_W'(j);
      end
    end
    o_valid = found;
  end

endmodule

// File: rtl/psram_xfer_arb.sv
// psram_xfer_arb
//   Shares one psram_core datapath between NUM_MST 64-bit bus requesters
//   and one 8-bit config requester. The winning request is latched into
//   holding registers that drive every core input for the whole transfer.
// Handshakes:
//   Requesters hold *_req_i (and payload) until a one-cycle *_gnt_o; the
//   payload is sampled in the grant cycle. A one-cycle *_done_o returns
//   completion with read data. Toward the core, core_xfer_valid_o is held
//   until core_xfer_ready_i is seen low (one cycle after acceptance);
//   core_xfer_done_i is only honoured in BUSY.
// Ports:
//   clk_i/rst_n_i                 clock, async active-low reset
//   mst_*                         packed per-master request/payload/response
//   cfg_*                         config-port request/payload/response
//   core_*                        held transfer toward psram_core
//   busy_o, owner_o, dbg_state_o  FSM status (owner NUM_MST = config)
module psram_xfer_arb
  import psram_xfer_arb_pkg::*;
#(
  parameter int NUM_MST       = 2,
  parameter int CFG_BURST_MAX = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_MST-1:0]       mst_req_i,
  input  logic [NUM_MST-1:0]       mst_rdwr_i,
  input  logic [NUM_MST*32-1:0]    mst_addr_i,
  input  logic [NUM_MST*64-1:0]    mst_wr_data_i,
  input  logic [NUM_MST*8-1:0]     mst_wr_mask_i,
  output logic [NUM_MST-1:0]       mst_gnt_o,
  output logic [NUM_MST-1:0]       mst_done_o,
  output logic [63:0]              mst_rd_data_o,
  input  logic                     cfg_req_i,
  input  logic                     cfg_rdwr_i,
  input  logic [31:0]              cfg_addr_i,
  input  logic [7:0]               cfg_wr_data_i,
  output logic                     cfg_gnt_o,
  output logic                     cfg_done_o,
  output logic [7:0]               cfg_rd_data_o,
  output logic                     core_xfer_valid_o,
  output logic                     core_xfer_rdwr_o,
  output logic                     core_cflg_o,
  output logic [31:0]              core_addr_o,
  output logic [7:0]               core_cfg_data_o,
  output logic [63:0]              core_bus_wr_data_o,
  output logic [7:0]               core_bus_wr_mask_o,
  input  logic                     core_xfer_ready_i,
  input  logic                     core_xfer_done_i,
  input  logic [63:0]              core_bus_rd_data_i,
  output logic                     busy_o,
  output logic [PSRAM_OWNER_W-1:0] owner_o,
  output logic [1:0]               dbg_state_o
);

  localparam int STREAK_W = $clog2(CFG_BURST_MAX + 1);
  localparam logic [PSRAM_OWNER_W-1:0] CFG_OWNER = PSRAM_OWNER_W'(NUM_MST);

  psram_arb_state_e           r_state;
  logic [PSRAM_OWNER_W-1:0]   r_rr_ptr;
  logic [STREAK_W-1:0]        r_cfg_streak;
  logic                       r_valid, r_rdwr, r_cflg;
  logic [31:0]                r_addr;
  logic [7:0]                 r_cfg_data, r_wr_mask;
  logic [63:0]                r_wr_data, r_cap, r_mst_rd;
  logic [7:0]                 r_cfg_rd;
  logic [PSRAM_OWNER_W-1:0]   r_owner;
  logic [NUM_MST-1:0]         r_mst_done;
  logic                       r_cfg_done;

  logic [NUM_MST-1:0]         w_rr_gnt;
  logic [PSRAM_OWNER_W-1:0]   w_rr_idx;
  logic                       w_rr_valid;
  logic                       w_any_mst, w_cfg_yield, w_can_grant, w_cfg_win, w_mst_win;
  logic                       w_sel_rdwr;
  logic [31:0]                w_sel_addr;
  logic [63:0]                w_sel_data;
  logic [7:0]                 w_sel_mask;

  psram_xfer_arb_rr #(.N(NUM_MST)) u_rr (
    .i_req   (mst_req_i),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_rr_gnt),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

  assign w_any_mst   = |mst_req_i;
  // After CFG_BURST_MAX back-to-back config grants with masters waiting,
  // the config port steps aside for exactly one master grant.
  assign w_cfg_yield = w_any_mst && (r_cfg_streak == STREAK_W'(CFG_BURST_MAX));
  // Grants are combinational in IDLE; gated by reset so nothing leaks out
  // while rst_n_i is low.
  assign w_can_grant = rst_n_i && (r_state == PSRAM_ARB_IDLE) && core_xfer_ready_i;
  assign w_cfg_win   = w_can_grant && cfg_req_i && !w_cfg_yield;
  assign w_mst_win   = w_can_grant && w_rr_valid && !w_cfg_win;

  assign mst_gnt_o = w_mst_win ? w_rr_gnt : '0;
  assign cfg_gnt_o = w_cfg_win;

  always_comb begin
    w_sel_rdwr = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_mask = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (w_rr_gnt[i]) begin
        w_sel_rdwr = mst_rdwr_i[i];
        w_sel_addr = mst_addr_i[32*i +: 32];
        w_sel_data = mst_wr_data_i[64*i +: 64];
        w_sel_mask = mst_wr_mask_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= PSRAM_ARB_IDLE;
      r_rr_ptr     <= '0;
      r_cfg_streak <= '0;
      r_valid      <= 1'b0;
      r_rdwr       <= 1'b0;
      r_cflg       <= 1'b0;
      r_addr       <= '0;
      r_cfg_data   <= '0;
      r_wr_data    <= '0;
      r_wr_mask    <= '0;
      r_cap        <= '0;
      r_mst_rd     <= '0;
      r_cfg_rd     <= '0;
      r_owner      <= '0;
      r_mst_done   <= '0;
      r_cfg_done   <= 1'b0;
    end else begin
      r_mst_done <= '0;
      r_cfg_done <= 1'b0;

      if (!w_any_mst || w_mst_win) begin
        r_cfg_streak <= '0;
      end else if (w_cfg_win) begin
        r_cfg_streak <= r_cfg_streak + STREAK_W'(1);
      end

      case (r_state)
        PSRAM_ARB_IDLE: begin
          if (w_cfg_win) begin
            r_rdwr     <= cfg_rdwr_i;
            r_cflg     <= 1'b1;
            r_addr     <= cfg_addr_i;
            r_cfg_data <= cfg_wr_data_i;
            r_wr_data  <= '0;
            r_wr_mask  <= '0;
            r_owner    <= CFG_OWNER;
            r_valid    <= 1'b1;
            r_state    <= PSRAM_ARB_ISSUE;
          end else if (w_mst_win) begin
            r_rdwr     <= w_sel_rdwr;
            r_cflg     <= 1'b0;
            r_addr     <= w_sel_addr;
            r_cfg_data <= '0;
            r_wr_data  <= w_sel_data;
            r_wr_mask  <= w_sel_mask;
            r_owner    <= w_rr_idx;
            r_rr_ptr   <= (w_rr_idx == PSRAM_OWNER_W'(NUM_MST - 1)) ? '0
                          : w_rr_idx + PSRAM_OWNER_W'(1);
            r_valid    <= 1'b1;
            r_state    <= PSRAM_ARB_ISSUE;
          end
        end
        PSRAM_ARB_ISSUE: begin
          // Ready dropping is the core's acknowledgement of the request.
          if (!core_xfer_ready_i) begin
            r_valid <= 1'b0;
            r_state <= PSRAM_ARB_BUSY;
          end
        end
        PSRAM_ARB_BUSY: begin
          if (core_xfer_done_i) begin
            r_cap   <= core_bus_rd_data_i;
            r_state <= PSRAM_ARB_RESP;
          end
        end
        PSRAM_ARB_RESP: begin
          if (r_owner == CFG_OWNER) begin
            r_cfg_done <= 1'b1;
            r_cfg_rd   <= r_cap[7:0];
          end else begin
            r_mst_done <= NUM_MST'(1) << r_owner;
            r_mst_rd   <= r_cap;
          end
          r_state <= PSRAM_ARB_IDLE;
        end
        default: r_state <= PSRAM_ARB_IDLE;
      endcase
    end
  end

  assign mst_done_o         = r_mst_done;
  assign mst_rd_data_o      = r_mst_rd;
  assign cfg_done_o         = r_cfg_done;
  assign cfg_rd_data_o      = r_cfg_rd;
  assign core_xfer_valid_o  = r_valid;
  assign core_xfer_rdwr_o   = r_rdwr;
  assign core_cflg_o        = r_cflg;
  assign core_addr_o        = r_addr;
  assign core_cfg_data_o    = r_cfg_data;
  assign core_bus_wr_data_o = r_wr_data;
  assign core_bus_wr_mask_o = r_wr_mask;
  assign busy_o             = (r_state != PSRAM_ARB_IDLE);
  assign owner_o            = r_owner;
  assign dbg_state_o        = r_state;

endmodule
